// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle CPU: word RAM plus an MMIO page
// (cycle counter, LED register, transmit FIFO, status) with zero-latency reads.
module data_mem_responder #(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Addres,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] readData,
    output logic [7:0]  led,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic          ram_hit;
    logic          mmio_hit;
    logic [1:0]    mmio_off;
    logic [AW-1:0] ram_idx;
    logic          wr_en;
    logic          cyc_hit;
    logic          led_hit;
    logic          tx_hit;
    logic          stat_hit;

    logic [31:0]   ram [RAM_WORDS];
    logic [31:0]   cycle_cnt;

    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          ovf;
    logic          uerr;
    logic          ovf_set;
    logic          ovf_clr;
    logic          uerr_set;
    logic          uerr_clr;
    logic [31:0]   status;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^Addres[1:0];

    assign ram_hit  = {2'b00, Addres[31:2]} < 32'(RAM_WORDS);
    assign mmio_hit = (Addres[31:4] == MMIO_BASE[31:4]);
    assign mmio_off = Addres[3:2];
    assign ram_idx  = Addres[AW+1:2];

    // Stores committed during reset are discarded for every target.
    assign wr_en    = MemWrite && !rst;
    assign cyc_hit  = !ram_hit && mmio_hit && (mmio_off == 2'd0);
    assign led_hit  = !ram_hit && mmio_hit && (mmio_off == 2'd1);
    assign tx_hit   = !ram_hit && mmio_hit && (mmio_off == 2'd2);
    assign stat_hit = !ram_hit && mmio_hit && (mmio_off == 2'd3);

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign tx_valid = !empty;
    assign tx_data  = fifo_mem[rd_ptr];

    assign push_req = wr_en && tx_hit;
    assign push_ok  = push_req && !full;
    assign pop      = tx_valid && tx_ready;

    assign ovf_set  = push_req && full;
    assign ovf_clr  = wr_en && stat_hit && WriteData[3];
    assign uerr_set = wr_en && !ram_hit && !mmio_hit;
    assign uerr_clr = wr_en && stat_hit && WriteData[2];

    assign status = {16'h0000, 8'(count), 4'h0, ovf, uerr, empty, full};

    // RAM and FIFO storage carry data only; they are never reset.
    always_ff @(posedge clk) begin
        if (wr_en && ram_hit) begin
            ram[ram_idx] <= WriteData;
        end
        if (push_ok) begin
            fifo_mem[wr_ptr] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            led       <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            uerr      <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (wr_en && led_hit) begin
                led <= WriteData[7:0];
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push_ok) - CW'(pop);
            // Sticky error flags: a new event in the same cycle beats the clear.
            ovf  <= ovf_set  || (ovf  && !ovf_clr);
            uerr <= uerr_set || (uerr && !uerr_clr);
        end
    end

    always_comb begin
        readData = 32'h0;
        if (ram_hit) begin
            readData = ram[ram_idx];
        end else if (mmio_hit) begin
            case (mmio_off)
                2'd0:    readData = cycle_cnt;
                2'd1:    readData = {24'h0, led};
                2'd2:    readData = 32'h0;
                default: readData = status;
            endcase
        end
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder side of the CPU data-memory interface: accepts the CPU's word address, write data and MemWrite strobe, and returns readData in the same cycle.
- Decodes the address into a word RAM and a small MMIO page: free-running cycle counter, LED register, transmit FIFO with valid/ready drain port, and status register.
- Sits between the single-cycle CPU data port and off-core consumers.

Parameters:
RAM_WORDS, 1024, RAM depth in 32-bit words; power of two; RAM occupies bytes 0 .. RAM_WORDS*4-1.
FIFO_DEPTH, 8, transmit FIFO entries; power of two, 2..128.
MMIO_BASE, 32'hFFFF_0000, base byte address of the 16-byte MMIO page.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
Addres  input  32  byte address from CPU; bits [1:0] ignored (word access only)
WriteData  input  32  store data from CPU
MemWrite  input  1  store strobe; write committed at the next rising edge
readData  output  32  load data, combinational from Addres and current state
led  output  8  LED register contents
tx_data  output  32  FIFO head word
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  consumer accepts head when tx_valid && tx_ready at a rising edge

Behaviour:
- Decode uses word address Addres[31:2].
  - RAM hit: Addres < RAM_WORDS*4.
  - MMIO hit: Addres[31:4] == MMIO_BASE[31:4].
  - MMIO offsets: 0x0 CYCLE (RO), 0x4 LED (RW, bits[7:0]), 0x8 TXDATA (WO), 0xC STATUS.
  - Anything else is unmapped.
- Reads have zero latency: readData is combinational, as the single-cycle CPU requires.
  - RAM: stored word.
  - CYCLE: counter value.
  - LED: {24'b0, led}.
  - TXDATA: 0.
  - STATUS: {16'b0, count[7:0], 4'b0, ovf, uerr, empty, full}.
  - Unmapped: 32'h0.
- Writes happen at the rising edge when MemWrite=1.
  - RAM word written.
  - LED <= WriteData[7:0].
  - CYCLE write ignored.
  - TXDATA: push request.
  - STATUS: W1C; WriteData[2] clears uerr, WriteData[3] clears ovf. Both set and clear in the same cycle: set wins.
  - Unmapped write: no state change except uerr <= 1.
- Read-after-write: a load of a word stored in the previous cycle returns the new value. No same-cycle bypass.
- CYCLE: increments by 1 every cycle out of reset and wraps 32'hFFFF_FFFF -> 0. Value in the first cycle after reset release is 0.
- TX FIFO: circular buffer with registered rd_ptr, wr_ptr and count (0..FIFO_DEPTH). Pointers wrap modulo FIFO_DEPTH.
  - push = MemWrite && TXDATA hit. Accepted only if the pre-edge count < FIFO_DEPTH.
  - A push while full is dropped and sets ovf, even if a pop occurs in the same cycle.
  - pop = tx_valid && tx_ready.
  - Push and pop in the same cycle with 0 < count < FIFO_DEPTH: both occur, count unchanged.
  - tx_valid = (count != 0). tx_data = mem[rd_ptr]. No fall-through: data pushed into an empty FIFO appears one cycle later.
  - tx_data is held stable while tx_valid && !tx_ready.
  - full = (count == FIFO_DEPTH); empty = (count == 0).
- Reset (synchronous, any time, including mid-burst):
  - CYCLE=0, led=0, uerr=0, ovf=0.
  - FIFO pointers and count = 0, so tx_valid=0, full=0, empty=1.
  - tx_data is don't-care while tx_valid=0.
  - RAM contents are not reset and are preserved.
  - A MemWrite asserted in the reset cycle is ignored for all targets.

Test Plan:
- Reset, then store 32'hDEADBEEF to 0x10 and load 0x10 next cycle -> readData=32'hDEADBEEF. Load 0x14 written earlier with 32'h1234 -> 32'h1234. Assert rst mid-run, then reload 0x10 -> still DEADBEEF.
- Hold rst 1 cycle, release, then sample CYCLE on 5 consecutive cycles -> 0,1,2,3,4. Force the counter to 32'hFFFF_FFFF (hierarchical deposit) -> next value 0. Store 7 to CYCLE -> counter continues unaffected.
- tx_ready=0, push 9 words 1..9 at FIFO_DEPTH=8 -> STATUS=32'h0000_0809 (count 8, ovf, full). Word 9 dropped. Raise tx_ready -> tx_data 1..8 on consecutive cycles, tx_valid falls after 8, STATUS empty bit=1.
- Empty FIFO: push 32'hA5 at edge N with tx_ready=1 -> tx_valid=0 during cycle N-1→N, tx_valid=1 and tx_data=32'hA5 after edge N, popped at edge N+1. Steady push+pop each cycle at count=3 -> count stays 3.
- Store to 0x8000_0000 (unmapped) -> load returns 0, STATUS bit2=1. Store 32'h4 to STATUS -> bit2 clears. Store 32'h1FF to LED -> led=8'hFF, LED readback 32'h0000_00FF.
- Assert rst with count=5 and ovf=1 and MemWrite pushing TXDATA in the same cycle -> next cycle tx_valid=0, STATUS=32'h0000_0002, led=0, no entry pushed.
